// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  // EX operand mux encodings
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Datapath <-> hazard controller signal bundle; master is the datapath, slave the controller.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
);
  logic [REG_AW-1:0] if_id_rs, if_id_rt;
  logic              id_uses_rs, id_uses_rt, id_is_branch, branch_taken;
  logic [REG_AW-1:0] id_ex_rs, id_ex_rt, id_ex_rd;
  logic              id_ex_regwrite, id_ex_memread;
  logic [REG_AW-1:0] ex_mem_rd;
  logic              ex_mem_regwrite, ex_mem_memread;
  logic [REG_AW-1:0] mem_wb_rd;
  logic              mem_wb_regwrite;
  logic              md_start, md_done;
  logic              pc_write_en, if_id_write_en, id_ex_write_en;
  logic              id_ex_bubble, ex_mem_bubble, if_id_flush;
  logic [1:0]        fwd_a, fwd_b;
  logic              fwd_id_a, fwd_id_b;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output if_id_rs, if_id_rt, id_uses_rs, id_uses_rt, id_is_branch, branch_taken,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_regwrite, id_ex_memread,
           ex_mem_rd, ex_mem_regwrite, ex_mem_memread, mem_wb_rd, mem_wb_regwrite,
           md_start, md_done,
    input  pc_write_en, if_id_write_en, id_ex_write_en, id_ex_bubble, ex_mem_bubble,
           if_id_flush, fwd_a, fwd_b, fwd_id_a, fwd_id_b, stall_cycles
  );

  modport slave (
    input  if_id_rs, if_id_rt, id_uses_rs, id_uses_rt, id_is_branch, branch_taken,
           id_ex_rs, id_ex_rt, id_ex_rd, id_ex_regwrite, id_ex_memread,
           ex_mem_rd, ex_mem_regwrite, ex_mem_memread, mem_wb_rd, mem_wb_regwrite,
           md_start, md_done,
    output pc_write_en, if_id_write_en, id_ex_write_en, id_ex_bubble, ex_mem_bubble,
           if_id_flush, fwd_a, fwd_b, fwd_id_a, fwd_id_b, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl_fwd_sel.sv
// Priority forwarding select for one EX operand: the younger EX/MEM result beats MEM/WB.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_regwrite,
  output logic [1:0]        sel
);
  localparam logic [REG_AW-1:0] ZERO = {REG_AW{1'b0}};

  // operand source priority compare
  always_comb begin
    sel = FWD_RF;
    if (ex_mem_regwrite && (ex_mem_rd != ZERO) && (ex_mem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mem_wb_regwrite && (mem_wb_rd != ZERO) && (mem_wb_rd == src)) begin
      sel = FWD_MEMWB;
    end else begin
      sel = FWD_RF;
    end
  end
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: EX/ID forwarding, load-use and branch stalls, mul/div freeze, flush, stall counter.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW         = 5,
  parameter int LOAD_STALL_CYC = 1,
  parameter int CNT_W          = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  hazard_ctrl_if.slave bus
);
  localparam int                LD_W     = $clog2(LOAD_STALL_CYC + 1);
  localparam logic [LD_W-1:0]   LD_INIT  = LD_W'(LOAD_STALL_CYC - 1);
  localparam logic [LD_W-1:0]   LD_ONE   = LD_W'(1);
  localparam logic [REG_AW-1:0] ZERO     = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam bit                LD_MULTI = (LOAD_STALL_CYC > 1);

  state_t            state_r;
  logic [LD_W-1:0]   ld_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              lu_haz_s, br_haz_s, front_stall_s, freeze_s, pc_en_s;
  logic [1:0]        fwd_a_s, fwd_b_s;

  function automatic logic match_x(input logic [REG_AW-1:0] r, input logic [REG_AW-1:0] rs,
                                   input logic [REG_AW-1:0] rt, input logic use_rs,
                                   input logic use_rt);
    return (r != ZERO) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

  fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
    .src(bus.id_ex_rs), .ex_mem_rd(bus.ex_mem_rd), .ex_mem_regwrite(bus.ex_mem_regwrite),
    .mem_wb_rd(bus.mem_wb_rd), .mem_wb_regwrite(bus.mem_wb_regwrite), .sel(fwd_a_s)
  );
  fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
    .src(bus.id_ex_rt), .ex_mem_rd(bus.ex_mem_rd), .ex_mem_regwrite(bus.ex_mem_regwrite),
    .mem_wb_rd(bus.mem_wb_rd), .mem_wb_regwrite(bus.mem_wb_regwrite), .sel(fwd_b_s)
  );

  assign lu_haz_s = bus.id_ex_memread &&
                    match_x(bus.id_ex_rd, bus.if_id_rs, bus.if_id_rt, bus.id_uses_rs, bus.id_uses_rt);
  assign br_haz_s = bus.id_is_branch &&
      ((bus.id_ex_regwrite &&
        match_x(bus.id_ex_rd, bus.if_id_rs, bus.if_id_rt, bus.id_uses_rs, bus.id_uses_rt)) ||
       (bus.ex_mem_memread &&
        match_x(bus.ex_mem_rd, bus.if_id_rs, bus.if_id_rt, bus.id_uses_rs, bus.id_uses_rt)));

  // stall/freeze decision; a mul/div issue outranks any front-end hazard
  always_comb begin
    front_stall_s = 1'b0;
    freeze_s      = 1'b0;
    case (state_r)
      RUN: begin
        if (bus.md_start && !bus.md_done) begin
          freeze_s = 1'b1;
        end else if (lu_haz_s || br_haz_s) begin
          front_stall_s = 1'b1;
        end else begin
          front_stall_s = 1'b0;
        end
      end
      LD_STALL: front_stall_s = 1'b1;
      MD_WAIT:  freeze_s      = !bus.md_done;
      default: begin
        front_stall_s = 1'b0;
        freeze_s      = 1'b0;
      end
    endcase
  end

  assign pc_en_s = !(front_stall_s || freeze_s);

  // pipeline controls, all forced low while reset is asserted
  always_comb begin
    bus.pc_write_en    = 1'b0;
    bus.if_id_write_en = 1'b0;
    bus.id_ex_write_en = 1'b0;
    bus.id_ex_bubble   = 1'b0;
    bus.ex_mem_bubble  = 1'b0;
    bus.if_id_flush    = 1'b0;
    bus.fwd_a          = FWD_RF;
    bus.fwd_b          = FWD_RF;
    bus.fwd_id_a       = 1'b0;
    bus.fwd_id_b       = 1'b0;
    if (rst_n) begin
      bus.pc_write_en    = pc_en_s;
      bus.if_id_write_en = pc_en_s;
      bus.id_ex_write_en = !freeze_s;
      bus.id_ex_bubble   = front_stall_s;
      bus.ex_mem_bubble  = freeze_s;
      bus.if_id_flush    = bus.branch_taken && pc_en_s;
      bus.fwd_a          = fwd_a_s;
      bus.fwd_b          = fwd_b_s;
      bus.fwd_id_a = bus.ex_mem_regwrite && !bus.ex_mem_memread &&
                     (bus.ex_mem_rd != ZERO) && (bus.ex_mem_rd == bus.if_id_rs);
      bus.fwd_id_b = bus.ex_mem_regwrite && !bus.ex_mem_memread &&
                     (bus.ex_mem_rd != ZERO) && (bus.ex_mem_rd == bus.if_id_rt);
    end else begin
      bus.pc_write_en = 1'b0;
    end
  end

  assign bus.stall_cycles = stall_cnt_r;

  // state machine, load-stall countdown and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= RUN;
      ld_cnt_r    <= {LD_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!pc_en_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      case (state_r)
        RUN: begin
          if (bus.md_start && !bus.md_done) begin
            state_r <= MD_WAIT;
          end else if (lu_haz_s && LD_MULTI) begin
            // first stall cycle happens here, the rest are counted down in LD_STALL
            ld_cnt_r <= LD_INIT;
            state_r  <= LD_STALL;
          end else begin
            state_r <= RUN;
          end
        end
        LD_STALL: begin
          if (ld_cnt_r <= LD_ONE) begin
            ld_cnt_r <= {LD_W{1'b0}};
            state_r  <= RUN;
          end else begin
            ld_cnt_r <= ld_cnt_r - LD_ONE;
          end
        end
        MD_WAIT: begin
          if (bus.md_done) begin
            state_r <= RUN;
          end else begin
            state_r <= MD_WAIT;
          end
        end
        default: begin
          state_r  <= RUN;
          ld_cnt_r <= {LD_W{1'b0}};
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl with LOAD_STALL_CYC=3.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(32)) bus ();

  hazard_ctrl #(.REG_AW(5), .LOAD_STALL_CYC(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] em_rd; logic em_rw; logic em_mr;
    logic [4:0] wb_rd; logic wb_rw;
    logic [4:0] ex_rs; logic [4:0] ex_rt; logic [4:0] ex_rd; logic ex_rw; logic ex_mr;
    logic [4:0] id_rs; logic [4:0] id_rt; logic u_rs; logic u_rt; logic br; logic tk;
    logic [1:0] e_fa; logic [1:0] e_fb; logic e_ida; logic e_idb; logic e_stall; logic e_flush;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_in();
    bus.if_id_rs = 5'd0; bus.if_id_rt = 5'd0; bus.id_uses_rs = 1'b0; bus.id_uses_rt = 1'b0;
    bus.id_is_branch = 1'b0; bus.branch_taken = 1'b0;
    bus.id_ex_rs = 5'd0; bus.id_ex_rt = 5'd0; bus.id_ex_rd = 5'd0;
    bus.id_ex_regwrite = 1'b0; bus.id_ex_memread = 1'b0;
    bus.ex_mem_rd = 5'd0; bus.ex_mem_regwrite = 1'b0; bus.ex_mem_memread = 1'b0;
    bus.mem_wb_rd = 5'd0; bus.mem_wb_regwrite = 1'b0;
    bus.md_start = 1'b0; bus.md_done = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    clear_in();
    bus.ex_mem_rd = v.em_rd; bus.ex_mem_regwrite = v.em_rw; bus.ex_mem_memread = v.em_mr;
    bus.mem_wb_rd = v.wb_rd; bus.mem_wb_regwrite = v.wb_rw;
    bus.id_ex_rs = v.ex_rs; bus.id_ex_rt = v.ex_rt; bus.id_ex_rd = v.ex_rd;
    bus.id_ex_regwrite = v.ex_rw; bus.id_ex_memread = v.ex_mr;
    bus.if_id_rs = v.id_rs; bus.if_id_rt = v.id_rt;
    bus.id_uses_rs = v.u_rs; bus.id_uses_rt = v.u_rt;
    bus.id_is_branch = v.br; bus.branch_taken = v.tk;
  endtask

  // expected controls for this cycle; stall counter reflects earlier cycles only
  task automatic chk_ctrl(input string tag, input logic stall, input logic freeze);
    logic pc;
    pc = !(stall || freeze);
    chk({tag, ".pc_we"}, 32'(bus.pc_write_en), 32'(pc));
    chk({tag, ".if_id_we"}, 32'(bus.if_id_write_en), 32'(pc));
    chk({tag, ".id_ex_we"}, 32'(bus.id_ex_write_en), 32'(!freeze));
    chk({tag, ".id_ex_bub"}, 32'(bus.id_ex_bubble), 32'(stall));
    chk({tag, ".ex_mem_bub"}, 32'(bus.ex_mem_bubble), 32'(freeze));
    chk({tag, ".stall_cycles"}, bus.stall_cycles, 32'(exp_cnt));
    if (!pc) exp_cnt++;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc_we"}, 32'(bus.pc_write_en), 32'd0);
    chk({tag, ".if_id_we"}, 32'(bus.if_id_write_en), 32'd0);
    chk({tag, ".id_ex_we"}, 32'(bus.id_ex_write_en), 32'd0);
    chk({tag, ".id_ex_bub"}, 32'(bus.id_ex_bubble), 32'd0);
    chk({tag, ".ex_mem_bub"}, 32'(bus.ex_mem_bubble), 32'd0);
    chk({tag, ".flush"}, 32'(bus.if_id_flush), 32'd0);
    chk({tag, ".fwd_a"}, 32'(bus.fwd_a), 32'd0);
    chk({tag, ".fwd_id_a"}, 32'(bus.fwd_id_a), 32'd0);
    chk({tag, ".stall_cycles"}, bus.stall_cycles, 32'd0);
  endtask

  task automatic set_load_use();
    clear_in();
    bus.id_ex_memread = 1'b1; bus.id_ex_regwrite = 1'b1; bus.id_ex_rd = 5'd5;
    bus.id_uses_rs = 1'b1; bus.if_id_rs = 5'd5;
  endtask

  initial begin
    //          em_rd  rw    mr    wb_rd  rw    ex_rs  ex_rt  ex_rd  rw    mr    id_rs  id_rt  urs   urt   br    tk    fa     fb     ida   idb   stall flush
    vecs[0] = '{5'd3, 1'b1, 1'b0, 5'd3, 1'b1, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{5'd3, 1'b1, 1'b0, 5'd4, 1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{5'd3, 1'b0, 1'b0, 5'd3, 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 5'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{5'd7, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8] = '{5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd6, 1'b1, 1'b0, 5'd0, 5'd6, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};

    // reset with inputs that would otherwise forward and stall
    set_load_use();
    bus.ex_mem_rd = 5'd3; bus.ex_mem_regwrite = 1'b1; bus.id_ex_rs = 5'd3;
    @(negedge clk); #1;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    clear_in();

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.fwd_a", i), 32'(bus.fwd_a), 32'(vecs[i].e_fa));
      chk($sformatf("v%0d.fwd_b", i), 32'(bus.fwd_b), 32'(vecs[i].e_fb));
      chk($sformatf("v%0d.fwd_id_a", i), 32'(bus.fwd_id_a), 32'(vecs[i].e_ida));
      chk($sformatf("v%0d.fwd_id_b", i), 32'(bus.fwd_id_b), 32'(vecs[i].e_idb));
      chk($sformatf("v%0d.flush", i), 32'(bus.if_id_flush), 32'(vecs[i].e_flush));
      chk_ctrl($sformatf("v%0d", i), vecs[i].e_stall, 1'b0);
    end

    // load-use: three stall cycles, then run
    @(negedge clk); set_load_use(); #1;
    chk_ctrl("lu0", 1'b1, 1'b0);
    @(negedge clk);
    clear_in();
    bus.ex_mem_rd = 5'd5; bus.ex_mem_regwrite = 1'b1; bus.ex_mem_memread = 1'b1;
    bus.id_uses_rs = 1'b1; bus.if_id_rs = 5'd5;
    #1; chk_ctrl("lu1", 1'b1, 1'b0);
    @(negedge clk); #1; chk_ctrl("lu2", 1'b1, 1'b0);
    @(negedge clk); #1; chk_ctrl("lu3", 1'b0, 1'b0);
    @(negedge clk); clear_in(); #1; chk_ctrl("lu4", 1'b0, 1'b0);

    // branch operand produced in EX: one stall, then forward from EX/MEM and flush
    @(negedge clk);
    clear_in();
    bus.id_is_branch = 1'b1; bus.id_uses_rs = 1'b1; bus.if_id_rs = 5'd2; bus.branch_taken = 1'b1;
    bus.id_ex_rd = 5'd2; bus.id_ex_regwrite = 1'b1;
    #1;
    chk_ctrl("br0", 1'b1, 1'b0);
    chk("br0.flush", 32'(bus.if_id_flush), 32'd0);
    chk("br0.fwd_id_a", 32'(bus.fwd_id_a), 32'd0);
    @(negedge clk);
    bus.id_ex_rd = 5'd0; bus.id_ex_regwrite = 1'b0;
    bus.ex_mem_rd = 5'd2; bus.ex_mem_regwrite = 1'b1;
    #1;
    chk_ctrl("br1", 1'b0, 1'b0);
    chk("br1.fwd_id_a", 32'(bus.fwd_id_a), 32'd1);
    chk("br1.flush", 32'(bus.if_id_flush), 32'd1);

    // mul/div issued alongside a load-use hazard: freeze 4 cycles, release on done
    @(negedge clk); set_load_use(); bus.md_start = 1'b1; #1;
    chk_ctrl("md0", 1'b0, 1'b1);
    for (int k = 1; k < 4; k++) begin
      @(negedge clk); clear_in(); #1;
      chk_ctrl($sformatf("md%0d", k), 1'b0, 1'b1);
    end
    @(negedge clk); bus.md_done = 1'b1; #1; chk_ctrl("md4", 1'b0, 1'b0);
    @(negedge clk); clear_in(); #1; chk_ctrl("md5", 1'b0, 1'b0);
    @(negedge clk); bus.md_start = 1'b1; bus.md_done = 1'b1; #1; chk_ctrl("md_same", 1'b0, 1'b0);
    @(negedge clk); clear_in(); #1; chk_ctrl("md_after", 1'b0, 1'b0);

    // reset in the middle of a load stall
    @(negedge clk); set_load_use(); #1; chk_ctrl("rs0", 1'b1, 1'b0);
    @(negedge clk); clear_in(); #1; chk_ctrl("rs1", 1'b1, 1'b0);
    #2; rst_n = 1'b0; #1;
    chk_reset("rs_mid");
    exp_cnt = 0;
    @(negedge clk); rst_n = 1'b1; clear_in(); #1; chk_ctrl("rs2", 1'b0, 1'b0);
    @(negedge clk); #1; chk_ctrl("rs3", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
